// File: rtl/axi4_read_data.sv
// DDR read-data return buffer: unstallable DDR beats into a small FIFO, drained
// as an AXI4-Stream master with TLAST framing, level/almost-full and sticky overflow.
module axi4_read_data #(
  parameter int DATA_WIDTH   = 512,
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 4,
  parameter int BURST_LEN    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      ddr_rdata,
  input  logic                       ddr_rdata_valid,
  output logic [DATA_WIDTH-1:0]      M_AXIS_TDATA,
  output logic                       M_AXIS_TVALID,
  input  logic                       M_AXIS_TREADY,
  output logic                       M_AXIS_TLAST,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       clear_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [LW-1:0] FULL_L  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L = LW'(DEPTH - AFULL_MARGIN);
  localparam logic [BW-1:0] LAST_B  = BW'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [BW-1:0]         beat_cnt;
  logic                  full, push, pop, drop;

  assign full  = (level == FULL_L);
  assign pop   = M_AXIS_TVALID && M_AXIS_TREADY;
  // a full FIFO still takes a beat when the head leaves on the same edge
  assign push  = ddr_rdata_valid && (!full || pop);
  assign drop  = ddr_rdata_valid && full && !pop;

  assign M_AXIS_TVALID = (level != '0);
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? mem[rd_ptr] : '0;
  assign M_AXIS_TLAST  = M_AXIS_TVALID && (beat_cnt == LAST_B);
  assign almost_full   = (level >= AFULL_L);

  // storage carries no reset; validity is tracked by level alone
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ddr_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      beat_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        beat_cnt <= (beat_cnt == LAST_B) ? '0 : beat_cnt + 1'b1;
      end
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi4_read_data.sv
// Self-checking bench for axi4_read_data: bench-side level/overflow model plus
// a scoreboard of expected {last,data} compared as beats leave the stream port.
module tb_axi4_read_data;
  localparam int DW = 512, DEPTH = 16, BL = 8;

  logic          clk = 0, rst = 1;
  logic [DW-1:0] ddr_rdata = '0;
  logic          ddr_rdata_valid = 0, M_AXIS_TREADY = 0, clear_overflow = 0;
  logic [DW-1:0] M_AXIS_TDATA;
  logic          M_AXIS_TVALID, M_AXIS_TLAST, almost_full, overflow;
  logic [4:0]    level;

  axi4_read_data #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_MARGIN(4), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .ddr_rdata(ddr_rdata), .ddr_rdata_valid(ddr_rdata_valid),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TLAST(M_AXIS_TLAST), .level(level), .almost_full(almost_full),
    .overflow(overflow), .clear_overflow(clear_overflow));

  always #5 clk = ~clk;

  typedef struct packed { logic last; logic [DW-1:0] data; } exp_t;
  exp_t sb[$];
  int compared = 0, mismatched = 0;
  int m_level = 0, push_cnt = 0, tlast_seen = 0;
  logic m_ovf = 0;

  // output monitor: scoreboard pop and stall-stability, sampled mid-cycle
  logic prev_stall = 0, held_l = 0;
  logic [DW-1:0] held_d = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        compared++;
        if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== held_d || M_AXIS_TLAST !== held_l) begin
          mismatched++;
          $display("FAIL stall_stable: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   M_AXIS_TVALID, M_AXIS_TDATA[63:0], M_AXIS_TLAST, held_d[63:0], held_l);
        end
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_beat: got d=%h with empty scoreboard", M_AXIS_TDATA[63:0]);
        end else begin
          e = sb.pop_front();
          if (M_AXIS_TLAST) tlast_seen++;
          if (M_AXIS_TDATA !== e.data || M_AXIS_TLAST !== e.last) begin
            mismatched++;
            $display("FAIL beat: got d=%h l=%b want d=%h l=%b",
                     M_AXIS_TDATA[63:0], M_AXIS_TLAST, e.data[63:0], e.last);
          end
        end
      end
      prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
      held_d = M_AXIS_TDATA;
      held_l = M_AXIS_TLAST;
    end
  end

  // one clock of stimulus; model decides push/drop and queues the expected beat
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
    logic p, q;
    ddr_rdata_valid = v; ddr_rdata = d; M_AXIS_TREADY = rdy; clear_overflow = clr;
    q = (m_level != 0) && rdy;
    p = v && (m_level < DEPTH || q);
    if (p) begin
      sb.push_back('{last: (push_cnt % BL) == BL-1, data: d});
      push_cnt++;
    end
    if (v && !p) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_level = m_level + int'(p) - int'(q);
    @(posedge clk); #1;
    ddr_rdata_valid = 0; clear_overflow = 0;
  endtask

  task automatic do_reset();
    rst = 1; ddr_rdata_valid = 0; M_AXIS_TREADY = 0; clear_overflow = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    sb.delete(); push_cnt = 0; m_level = 0; m_ovf = 0;
  endtask

  task automatic drain(input bit rand_rdy);
    for (int i = 0; i < 200 && m_level != 0; i++)
      cycle(0, '0, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 0);
    M_AXIS_TREADY = 0;
  endtask

  task automatic test_reset();
    rst = 1; #3;
    compared++;
    if (M_AXIS_TVALID !== 0 || M_AXIS_TDATA !== '0 || M_AXIS_TLAST !== 0 || level !== 0 ||
        almost_full !== 0 || overflow !== 0) begin
      mismatched++;
      $display("FAIL reset_state: got v=%b l=%b lvl=%0d af=%b ovf=%b want all 0",
               M_AXIS_TVALID, M_AXIS_TLAST, level, almost_full, overflow);
    end
    do_reset();
  endtask

  task automatic test_single_beat();
    logic [DW-1:0] a5;
    do_reset();
    a5 = {64{8'hA5}};
    cycle(1, a5, 1, 0);
    compared++;
    if (M_AXIS_TVALID !== 1 || M_AXIS_TDATA !== a5 || level !== 1) begin
      mismatched++;
      $display("FAIL single_first: got v=%b d=%h lvl=%0d want v=1 d=%h lvl=1",
               M_AXIS_TVALID, M_AXIS_TDATA[63:0], level, a5[63:0]);
    end
    cycle(0, '0, 1, 0);
    compared++;
    if (level !== 0 || overflow !== 0 || M_AXIS_TVALID !== 0) begin
      mismatched++;
      $display("FAIL single_after: got lvl=%0d ovf=%b v=%b want 0 0 0", level, overflow, M_AXIS_TVALID);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, DW'(i), 0, 0);
      compared++;
      if (almost_full !== (i + 1 >= 12) || int'(level) !== i + 1) begin
        mismatched++;
        $display("FAIL fill_af: step %0d got af=%b lvl=%0d want af=%b lvl=%0d",
                 i, almost_full, level, (i + 1 >= 12), i + 1);
      end
    end
    cycle(1, DW'(16), 0, 0);
    compared++;
    if (overflow !== 1 || level !== 16) begin
      mismatched++;
      $display("FAIL drop: got ovf=%b lvl=%0d want ovf=1 lvl=16", overflow, level);
    end
    drain(0);
    compared++;
    if (sb.size() != 0 || M_AXIS_TVALID !== 0 || overflow !== 1) begin
      mismatched++;
      $display("FAIL fill_drain: got left=%0d v=%b ovf=%b want 0 0 1", sb.size(), M_AXIS_TVALID, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, DW'(32'h100 + i), 0, 0);
    cycle(1, DW'(32'hBEEF), 1, 0);
    compared++;
    if (level !== 16 || overflow !== 0) begin
      mismatched++;
      $display("FAIL full_pushpop: got lvl=%0d ovf=%b want lvl=16 ovf=0", level, overflow);
    end
    drain(0);
    compared++;
    if (sb.size() != 0 || M_AXIS_TVALID !== 0) begin
      mismatched++;
      $display("FAIL full_drain: got left=%0d v=%b want 0 0", sb.size(), M_AXIS_TVALID);
    end
  endtask

  task automatic test_tlast_framing();
    int t0;
    do_reset();
    t0 = tlast_seen;
    for (int i = 0; i < 24; i++) cycle(1, DW'(32'h2000 + i), 1'($urandom_range(0, 3) != 0), 0);
    drain(1);
    compared++;
    if (tlast_seen - t0 != 3 || sb.size() != 0 || overflow !== 0) begin
      mismatched++;
      $display("FAIL tlast_count: got %0d last beats left=%0d ovf=%b want 3 0 0",
               tlast_seen - t0, sb.size(), overflow);
    end
  endtask

  task automatic test_overflow_clear();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, DW'(i), 0, 0);
    cycle(1, DW'(99), 0, 1);
    compared++;
    if (overflow !== 1) begin
      mismatched++;
      $display("FAIL clr_priority: got ovf=%b want 1", overflow);
    end
    cycle(0, '0, 0, 1);
    compared++;
    if (overflow !== 0) begin
      mismatched++;
      $display("FAIL clr_alone: got ovf=%b want 0", overflow);
    end
    drain(0);
  endtask

  task automatic test_reset_mid();
    int t0;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, DW'(32'h300 + i), 1, 0);
    cycle(0, '0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, DW'(32'h400 + i), 0, 0);
    compared++;
    if (level !== 5) begin
      mismatched++;
      $display("FAIL pre_reset_level: got %0d want 5", level);
    end
    #2 rst = 1;
    #1;
    compared++;
    if (M_AXIS_TVALID !== 0 || M_AXIS_TDATA !== '0 || level !== 0 || overflow !== 0) begin
      mismatched++;
      $display("FAIL async_reset: got v=%b d=%h lvl=%0d ovf=%b want all 0",
               M_AXIS_TVALID, M_AXIS_TDATA[63:0], level, overflow);
    end
    do_reset();
    t0 = tlast_seen;
    for (int i = 0; i < 8; i++) cycle(1, DW'(32'h500 + i), 1, 0);
    drain(0);
    compared++;
    if (tlast_seen - t0 != 1 || sb.size() != 0) begin
      mismatched++;
      $display("FAIL post_reset_tlast: got %0d last beats left=%0d want 1 0", tlast_seen - t0, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_fill_overflow();
    test_full_push_pop();
    test_tlast_framing();
    test_overflow_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/axi4_read_data.md
# axi4_read_data

Return path for DDR read data: accepts 512-bit beats from the DDR read interface as single-cycle strobes that cannot be stalled, buffers them in a small FIFO, and presents them to downstream logic as an AXI4-Stream master with full backpressure. It sits between the DDR controller read port and the host-bound stream. It is the read-side counterpart of the write-data stream slave that feeds `ddr_wdata`. Because the DDR side cannot be throttled, the block also provides a level/almost-full indication for the read-command issuer and a sticky overflow flag.

## Interface
Parameters:
- `DATA_WIDTH`, 512: beat width in bits.
- `DEPTH`, 16: number of FIFO entries; must be a power of two and at least 2.
- `AFULL_MARGIN`, 4: `almost_full` asserts when `level` ≥ `DEPTH - AFULL_MARGIN`.
- `BURST_LEN`, 8: number of output beats per packet; `M_AXIS_TLAST` marks every `BURST_LEN`-th beat. Must be at least 1.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ddr_rdata`  in  DATA_WIDTH  read data from the DDR controller.
- `ddr_rdata_valid`  in  1  one beat is present this cycle; cannot be back-pressured.
- `M_AXIS_TDATA`  out  DATA_WIDTH  stream data (the FIFO head).
- `M_AXIS_TVALID`  out  1  FIFO not empty.
- `M_AXIS_TREADY`  in  1  downstream accepts the beat.
- `M_AXIS_TLAST`  out  1  current beat is the last of a `BURST_LEN` packet.
- `level`  out  $clog2(DEPTH+1)  current occupancy.
- `almost_full`  out  1  threshold flag for the command issuer.
- `overflow`  out  1  sticky: a beat was dropped.
- `clear_overflow`  in  1  synchronous clear of `overflow`.

## Operation
- Storage:
  - FIFO of `DEPTH` entries with `$clog2(DEPTH)`-bit read and write pointers; both pointers wrap modulo `DEPTH`.
  - A separate occupancy counter `level` runs from 0 to `DEPTH`.
  - Memory contents are not reset.
- Push = `ddr_rdata_valid && (level < DEPTH || pop)`.
  - When full, a push is still accepted if a pop occurs in the same cycle (the freed slot is reused).
- Pop = `M_AXIS_TVALID && M_AXIS_TREADY`.
- Level update:
  - Push only: `level + 1`.
  - Pop only: `level - 1`.
  - Push and pop together: `level` unchanged.
- Drop: `ddr_rdata_valid` while `level == DEPTH` and no pop.
  - The beat is discarded; pointers and `level` are unchanged.
  - `overflow` is set to 1 on the next edge.
- `overflow`:
  - Once set, holds until `clear_overflow` or `rst`.
  - If a drop and `clear_overflow` occur in the same cycle, set wins (flag = 1).
- Stream outputs:
  - `M_AXIS_TVALID = (level != 0)`.
  - `M_AXIS_TDATA = mem[rd_ptr]` when `TVALID` is 1, otherwise forced to 0.
  - `TDATA`/`TVALID` are stable while `TVALID && !TREADY`, as AXI-Stream requires.
- TLAST beat counter:
  - Counts pops from 0 to `BURST_LEN-1` and wraps to 0.
  - `M_AXIS_TLAST = TVALID && (beat_cnt == BURST_LEN-1)`.
  - With `BURST_LEN = 1`, every beat is last.
  - The counter advances only on pop, never on push or drop.
- `almost_full` is combinational from `level`.

## Timing
- Reset values (asynchronous, take effect immediately):
  - pointers = 0, `level` = 0, `beat_cnt` = 0, `overflow` = 0.
  - Hence `M_AXIS_TVALID` = 0, `TDATA` = 0, `TLAST` = 0, `almost_full` = 0.
- Latency:
  - A beat strobed in cycle N into an empty FIFO gives `TVALID = 1` with that data in cycle N+1.
  - The beat can be popped no earlier than the N+1 edge.
- Throughput: with `TREADY` held at 1, one beat per cycle is sustained indefinitely without drops.
- Full-and-popping case: `level` stays at `DEPTH`, there is no drop, and `overflow` stays 0.
- Reset mid-operation:
  - All buffered beats are discarded and the packet position returns to 0.
  - The first post-reset beat has `TLAST` only if `BURST_LEN = 1`.
- `level`, `almost_full`, `overflow` and `TLAST` update on the same edge as the pointer movement that causes them; none of them adds a cycle of lag.

## Test plan
- Single beat, `TREADY = 1`:
  - Stimulus: strobe `0xA5..A5` in cycle 0.
  - Required: `TVALID = 1` with `TDATA = 0xA5..A5` in cycle 1; `level` goes 0 → 1 → 0; `overflow` stays 0.
- Backpressure fill:
  - Stimulus: `TREADY = 0`, strobe 16 incrementing beats.
  - Required: `level = 16`; `almost_full` first asserts when `level` reaches 12.
  - Stimulus: a 17th beat.
  - Required: `overflow = 1`, `level` stays 16.
  - Stimulus: release `TREADY`.
  - Required: beats 0–15 come out in order; beat 16 is absent.
- Full with simultaneous push and pop:
  - Stimulus: `level = 16`, then `ddr_rdata_valid = 1` and `TREADY = 1` in the same cycle.
  - Required: no drop, `level` stays 16, `overflow` stays 0, and the new beat appears last.
- TLAST framing:
  - Stimulus: `BURST_LEN = 8`, 24 beats streamed with random `TREADY` stalls.
  - Required: `TLAST` on output beats 7, 15 and 23 only; `TDATA`/`TLAST` stable during every stall.
- Overflow clear priority:
  - Stimulus: a drop and `clear_overflow` in the same cycle.
  - Required: `overflow = 1`.
  - Stimulus: `clear_overflow` alone next cycle.
  - Required: `overflow = 0`.
- Reset mid-stream:
  - Stimulus: assert `rst` asynchronously with `level = 5` and `beat_cnt = 3`.
  - Required: `TVALID`, `TDATA`, `level` and `overflow` all read 0 immediately.
  - Stimulus: after release, send 8 beats.
  - Required: `TLAST` on the 8th.
